write_buffer: RTL and testbench

WRITE_BUFFER -- requirements
Module: write_buffer

---
 rtl/write_buffer.sv | 156 +++++++++++++++
 tb/tb_write_buffer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// Write buffer between the cache and memory: a circular FIFO of line writebacks
// drained to memory in the background. Define WB_FORWARD_EN to forward buffered data on read hits.
module write_buffer #(
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         proc_reset_n,
   input  logic         cache_read,
   input  logic         cache_write,
   input  logic [27:0]  cache_addr,
   input  logic [127:0] cache_wdata,
   output logic [127:0] cache_rdata,
   output logic         cache_ready,
   output logic         mem_read,
   output logic         mem_write,
   output logic [27:0]  mem_addr,
   output logic [127:0] mem_wdata,
   input  logic [127:0] mem_rdata,
   input  logic         mem_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);

   typedef enum logic [1:0] {IDLE, DRAIN, READ, RESP} state_t;

   state_t             state;
   logic [27:0]        addr_q [DEPTH];
   logic [127:0]       data_q [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic               enq;
   logic               deq;

   // Requests are ignored while cache_ready is high so a held request is never accepted twice.
   assign enq = cache_write && !cache_ready && (count < CNT_W'(DEPTH));
   assign deq = (state == DRAIN) && mem_ready;

`ifdef WB_FORWARD_EN
   logic               read_req;
   logic               fwd_hit;
   logic [127:0]       fwd_data;
   logic [PTR_W-1:0]   fwd_idx;

   assign read_req = cache_read && !cache_ready;

   // Scan oldest to youngest so the last match, the youngest write, wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = head;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (addr_q[fwd_idx] == cache_addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = data_q[fwd_idx];
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (enq) begin
         addr_q[tail] <= cache_addr;
         data_q[tail] <= cache_wdata;
      end
   end

   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state       <= IDLE;
         head        <= '0;
         tail        <= '0;
         count       <= '0;
         cache_ready <= 1'b0;
         cache_rdata <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         mem_addr    <= '0;
         mem_wdata   <= '0;
      end else begin
         cache_ready <= enq;
         if (enq) begin
            tail <= tail + PTR_W'(1);
         end
         if (deq) begin
            head <= head + PTR_W'(1);
         end
         count <= count + CNT_W'(enq) - CNT_W'(deq);

         case (state)
            IDLE: begin
               // A held read blocks draining even in the cycle it cannot yet be accepted.
               if (cache_read) begin
                  if (!cache_ready) begin
`ifdef WB_FORWARD_EN
                     if (fwd_hit) begin
                        cache_ready <= 1'b1;
                        cache_rdata <= fwd_data;
                     end else begin
                        state    <= READ;
                        mem_read <= 1'b1;
                        mem_addr <= cache_addr;
                     end
`else
                     if (count == '0) begin
                        state    <= READ;
                        mem_read <= 1'b1;
                        mem_addr <= cache_addr;
                     end else begin
                        state     <= DRAIN;
                        mem_write <= 1'b1;
                        mem_addr  <= addr_q[head];
                        mem_wdata <= data_q[head];
                     end
`endif
                  end
               end else if (count != '0) begin
                  state     <= DRAIN;
                  mem_write <= 1'b1;
                  mem_addr  <= addr_q[head];
                  mem_wdata <= data_q[head];
               end
            end
            DRAIN: begin
`ifdef WB_FORWARD_EN
               if (read_req && fwd_hit) begin
                  cache_ready <= 1'b1;
                  cache_rdata <= fwd_data;
               end
`endif
               if (mem_ready) begin
                  mem_write <= 1'b0;
                  state     <= IDLE;
               end
            end
            READ: begin
               if (mem_ready) begin
                  mem_read    <= 1'b0;
                  cache_rdata <= mem_rdata;
                  cache_ready <= 1'b1;
                  state       <= RESP;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_write_buffer.sv
// Directed self-checking bench for write_buffer (DEPTH=4); expectations follow WB_FORWARD_EN when defined.
module tb_write_buffer;

   localparam int DEPTH = 4;

   logic         clk = 1'b0;
   logic         proc_reset_n = 1'b0;
   logic         cache_read = 1'b0;
   logic         cache_write = 1'b0;
   logic [27:0]  cache_addr = '0;
   logic [127:0] cache_wdata = '0;
   logic [127:0] cache_rdata;
   logic         cache_ready;
   logic         mem_read;
   logic         mem_write;
   logic [27:0]  mem_addr;
   logic [127:0] mem_wdata;
   logic [127:0] mem_rdata = '0;
   logic         mem_ready = 1'b0;

   int checks = 0;
   int fails  = 0;

   localparam logic [127:0] DATA_A = 128'hAAAA_0000_1111_2222_3333_4444_5555_000A;
   localparam logic [127:0] DATA_B = 128'hBBBB_0000_6666_7777_8888_9999_CCCC_000B;
   localparam logic [127:0] DATA_C = 128'hCCCC_1234_5678_9ABC_DEF0_0FED_CBA9_000C;
   localparam logic [127:0] DATA_D = 128'hDDDD_FFFF_EEEE_0000_1357_2468_ACE0_000D;

   write_buffer #(.DEPTH(DEPTH)) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .cache_read   (cache_read),
      .cache_write  (cache_write),
      .cache_addr   (cache_addr),
      .cache_wdata  (cache_wdata),
      .cache_rdata  (cache_rdata),
      .cache_ready  (cache_ready),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
      checks++;
      if (observed !== expected) begin
         fails++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic rd, input logic wr, input logic [27:0] addr, input logic [127:0] wdata);
      cache_read  = rd;
      cache_write = wr;
      cache_addr  = addr;
      cache_wdata = wdata;
   endtask

   task automatic setMem(input logic rdy, input logic [127:0] rdata);
      mem_ready = rdy;
      mem_rdata = rdata;
   endtask

   task automatic doReset();
      proc_reset_n = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0);
      setMem(1'b0, '0);
      step();
      step();
      proc_reset_n = 1'b1;
      step();
   endtask

   // Present one write, wait (bounded) for its completion pulse, then idle one cycle.
   task automatic doWrite(input logic [27:0] addr, input logic [127:0] data);
      int lat;
      lat = 0;
      applyStimulus(1'b0, 1'b1, addr, data);
      for (int i = 1; i <= 20; i++) begin
         step();
         if (cache_ready) begin
            lat = i;
            break;
         end
      end
      checkOutput("write_latency", lat, 1);
      applyStimulus(1'b0, 1'b0, '0, '0);
      step();
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Reset values
      doReset();
      checkOutput("rst_cache_ready", cache_ready, 0);
      checkOutput("rst_cache_rdata", cache_rdata, 0);
      checkOutput("rst_mem_read", mem_read, 0);
      checkOutput("rst_mem_write", mem_write, 0);
      checkOutput("rst_mem_addr", mem_addr, 0);
      checkOutput("rst_mem_wdata", mem_wdata, 0);
      checkOutput("rst_count", dut.count, 0);

      // Single write and drain
      $display("[TB] single write and drain");
      doWrite(28'h10, DATA_A);
      checkOutput("drain_mem_write", mem_write, 1);
      checkOutput("drain_mem_addr", mem_addr, 28'h10);
      checkOutput("drain_mem_wdata", mem_wdata, DATA_A);
      checkOutput("drain_mem_read", mem_read, 0);
      setMem(1'b1, '0);
      step();
      setMem(1'b0, '0);
      checkOutput("drain_done_mem_write", mem_write, 0);
      checkOutput("drain_done_count", dut.count, 0);

      // Fill to DEPTH with memory stalled, then a fifth write stalls
      $display("[TB] full buffer stall");
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         doWrite(28'h100 + 28'(i), DATA_B + 128'(i));
      end
      checkOutput("full_count", dut.count, DEPTH);
      checkOutput("full_mem_addr", mem_addr, 28'h100);
      applyStimulus(1'b0, 1'b1, 28'h200, DATA_D);
      for (int i = 0; i < 3; i++) begin
         step();
         checkOutput("full_stall_ready", cache_ready, 0);
      end
      setMem(1'b1, '0);
      step();
      setMem(1'b0, '0);
      checkOutput("deq_cycle_ready", cache_ready, 0);
      checkOutput("deq_cycle_count", dut.count, DEPTH - 1);
      step();
      checkOutput("fifth_accept_ready", cache_ready, 1);
      checkOutput("fifth_accept_count", dut.count, DEPTH);
      checkOutput("second_drain_addr", mem_addr, 28'h101);
      applyStimulus(1'b0, 1'b0, '0, '0);

      // Two writes to the same address, then a read of it
      $display("[TB] read after repeated writes");
      doReset();
      doWrite(28'h20, DATA_A);
      doWrite(28'h20, DATA_B);
      applyStimulus(1'b1, 1'b0, 28'h20, '0);
`ifdef WB_FORWARD_EN
      step();
      checkOutput("fwd_ready", cache_ready, 1);
      checkOutput("fwd_rdata", cache_rdata, DATA_B);
      checkOutput("fwd_no_mem_read", mem_read, 0);
      applyStimulus(1'b0, 1'b0, '0, '0);
      step();
      checkOutput("fwd_ready_one_cycle", cache_ready, 0);
      checkOutput("fwd_no_mem_read_after", mem_read, 0);
`else
      step();
      checkOutput("nofwd_wait_ready", cache_ready, 0);
      checkOutput("nofwd_first_wdata", mem_wdata, DATA_A);
      setMem(1'b1, '0);
      step();
      setMem(1'b0, '0);
      checkOutput("nofwd_first_done", mem_write, 0);
      step();
      checkOutput("nofwd_second_write", mem_write, 1);
      checkOutput("nofwd_second_wdata", mem_wdata, DATA_B);
      checkOutput("nofwd_second_no_read", mem_read, 0);
      setMem(1'b1, '0);
      step();
      setMem(1'b0, '0);
      checkOutput("nofwd_empty_count", dut.count, 0);
      step();
      checkOutput("nofwd_mem_read", mem_read, 1);
      checkOutput("nofwd_mem_read_addr", mem_addr, 28'h20);
      checkOutput("nofwd_mem_write_low", mem_write, 0);
      setMem(1'b1, DATA_D);
      step();
      applyStimulus(1'b0, 1'b0, '0, '0);
      setMem(1'b0, '0);
      checkOutput("nofwd_resp_ready", cache_ready, 1);
      checkOutput("nofwd_resp_rdata", cache_rdata, DATA_D);
      step();
      checkOutput("nofwd_resp_one_cycle", cache_ready, 0);
`endif

      // Read miss with one unrelated entry buffered
      $display("[TB] read miss with pending write");
      doReset();
      applyStimulus(1'b0, 1'b1, 28'h40, DATA_A);
      step();
      checkOutput("miss_wr_ready", cache_ready, 1);
      applyStimulus(1'b1, 1'b0, 28'h30, '0);
      step();
      checkOutput("miss_hold_mem_write", mem_write, 0);
      checkOutput("miss_hold_mem_read", mem_read, 0);
      step();
`ifndef WB_FORWARD_EN
      checkOutput("miss_drain_first", mem_write, 1);
      checkOutput("miss_drain_addr", mem_addr, 28'h40);
      setMem(1'b1, '0);
      step();
      setMem(1'b0, '0);
      step();
`endif
      checkOutput("miss_mem_read", mem_read, 1);
      checkOutput("miss_mem_write_low", mem_write, 0);
      checkOutput("miss_mem_addr", mem_addr, 28'h30);
      setMem(1'b1, DATA_C);
      step();
      applyStimulus(1'b0, 1'b0, '0, '0);
      setMem(1'b0, '0);
      checkOutput("miss_resp_ready", cache_ready, 1);
      checkOutput("miss_resp_rdata", cache_rdata, DATA_C);
      checkOutput("miss_resp_mem_read", mem_read, 0);
      step();
      checkOutput("miss_resp_one_cycle", cache_ready, 0);
`ifdef WB_FORWARD_EN
      step();
      checkOutput("miss_then_drain", mem_write, 1);
      checkOutput("miss_then_drain_addr", mem_addr, 28'h40);
`endif

      // Asynchronous reset during a drain
      $display("[TB] reset during drain");
      doReset();
      doWrite(28'h50, DATA_B);
      checkOutput("pre_rst_mem_write", mem_write, 1);
      proc_reset_n = 1'b0;
      #1;
      checkOutput("async_rst_mem_write", mem_write, 0);
      checkOutput("async_rst_count", dut.count, 0);
      checkOutput("async_rst_mem_addr", mem_addr, 0);
      step();
      proc_reset_n = 1'b1;
      setMem(1'b1, DATA_C);
      step();
      setMem(1'b0, '0);
      checkOutput("stale_ready_cache_ready", cache_ready, 0);
      checkOutput("stale_ready_count", dut.count, 0);
      checkOutput("stale_ready_mem_write", mem_write, 0);
      step();
      checkOutput("stale_idle_mem_write", mem_write, 0);
      checkOutput("stale_idle_mem_read", mem_read, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
